// File: rtl/bnn_fc_engine.sv
// Binary fully-connected layer engine: streams input/weight words, accumulates
// XNOR-popcount per neuron, thresholds each neuron and tracks the argmax class.
module bnn_fc_engine #(
  parameter int IL     = 48,
  parameter int NWORD  = 54,
  parameter int NOUT   = 10,
  parameter int RLAT   = 1,
  parameter int THRESH = IL*NWORD/2,
  localparam int AW = ($clog2(IL*NWORD+1) > 1) ? $clog2(IL*NWORD+1) : 1,
  localparam int RW = ($clog2(NWORD) > 1) ? $clog2(NWORD) : 1,
  localparam int WW = ($clog2(NOUT*NWORD) > 1) ? $clog2(NOUT*NWORD) : 1,
  localparam int CW = ($clog2(NOUT) > 1) ? $clog2(NOUT) : 1
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSTART,
  input  logic [IL-1:0] iDATA,
  input  logic [IL-1:0] iWEIGHT,
  output logic [RW-1:0] oRADDR,
  output logic [WW-1:0] oWADDR,
  output logic          oREN,
  output logic          oBUSY,
  output logic          oDONE,
  output logic [NOUT-1:0] oDATA,
  output logic [CW-1:0] oCLASS,
  output logic [AW-1:0] oSCORE
);

  localparam int DW = ($clog2(RLAT+1) > 1) ? $clog2(RLAT+1) : 1;
  localparam logic [AW-1:0] THR = AW'(THRESH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stateT;

  stateT state, nextState;

  logic [RW-1:0] wordCnt;
  logic [CW-1:0] neuronCnt;
  logic [DW-1:0] drainCnt;
  logic [AW-1:0] acc, accNext, popCnt, maxSum;
  logic [CW-1:0] maxCls;
  logic [RLAT-1:0] pipeValid, pipeLast;
  logic [CW-1:0] pipeNeuron [RLAT];
  logic lastWord, lastIssue, alignValid, alignLast, newMax;
  logic [CW-1:0] alignNeuron;

  assign lastWord    = (wordCnt == RW'(NWORD-1));
  assign lastIssue   = lastWord && (neuronCnt == CW'(NOUT-1));
  assign alignValid  = pipeValid[RLAT-1];
  assign alignLast   = pipeLast[RLAT-1];
  assign alignNeuron = pipeNeuron[RLAT-1];
  assign popCnt      = AW'($countones(~(iDATA ^ iWEIGHT)));
  assign accNext     = acc + popCnt;
  assign newMax      = (alignNeuron == '0) || (accNext > maxSum);

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iSTART) nextState = RUN;
      RUN:     if (lastIssue) nextState = DRAIN;
      DRAIN:   if (drainCnt == DW'(RLAT-1)) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    oREN   = (state == RUN);
    oBUSY  = (state == RUN) || (state == DRAIN);
    oDONE  = (state == DONE);
    oRADDR = '0;
    oWADDR = '0;
    if (state == RUN) begin
      oRADDR = wordCnt;
      oWADDR = WW'(neuronCnt) * WW'(NWORD) + WW'(wordCnt);
    end
  end

  // Counters sit at zero while idle, so a run always starts from word 0 of neuron 0.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wordCnt   <= '0;
      neuronCnt <= '0;
      drainCnt  <= '0;
    end else begin
      drainCnt <= (state == DRAIN) ? drainCnt + DW'(1) : '0;
      if (state == RUN) begin
        if (!lastWord) begin
          wordCnt <= wordCnt + RW'(1);
        end else begin
          wordCnt <= '0;
          if (!lastIssue) neuronCnt <= neuronCnt + CW'(1);
        end
      end else if (state == IDLE) begin
        wordCnt   <= '0;
        neuronCnt <= '0;
      end
    end
  end

  // Tags travel alongside the memory reads so they line up with returned data.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pipeValid <= '0;
      pipeLast  <= '0;
      for (int i = 0; i < RLAT; i++) pipeNeuron[i] <= '0;
    end else begin
      pipeValid[0]  <= (state == RUN);
      pipeLast[0]   <= (state == RUN) && lastWord;
      pipeNeuron[0] <= neuronCnt;
      for (int i = 1; i < RLAT; i++) begin
        pipeValid[i]  <= pipeValid[i-1];
        pipeLast[i]   <= pipeLast[i-1];
        pipeNeuron[i] <= pipeNeuron[i-1];
      end
    end
  end

  // Ties keep the lowest index; the final neuron publishes class/score directly.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      acc    <= '0;
      maxSum <= '0;
      maxCls <= '0;
      oDATA  <= '0;
      oCLASS <= '0;
      oSCORE <= '0;
    end else if (state == IDLE && iSTART) begin
      acc    <= '0;
      maxSum <= '0;
      maxCls <= '0;
    end else if (alignValid) begin
      acc <= alignLast ? '0 : accNext;
      if (alignLast) begin
        oDATA[alignNeuron] <= (accNext >= THR);
        if (newMax) begin
          maxSum <= accNext;
          maxCls <= alignNeuron;
        end
        if (alignNeuron == CW'(NOUT-1)) begin
          oCLASS <= newMax ? alignNeuron : maxCls;
          oSCORE <= newMax ? accNext : maxSum;
        end
      end
    end
  end

endmodule

// File: tb/tb_bnn_fc_engine.sv
// Scoreboard bench for bnn_fc_engine: a 2-cycle memory model feeds the engine,
// and expected results from a plain-arithmetic reference are checked at oDONE.
module tb_bnn_fc_engine;

  localparam int IL = 8, NWORD = 4, NOUT = 3, RLAT = 2, THR = 16;
  localparam int N = NOUT*NWORD, LAT = N + RLAT + 1;

  logic iCLK = 1'b0;
  logic iRST, iSTART;
  logic [7:0] iDATA, iWEIGHT;
  logic [1:0] oRADDR;
  logic [3:0] oWADDR;
  logic oREN, oBUSY, oDONE;
  logic [2:0] oDATA;
  logic [1:0] oCLASS;
  logic [5:0] oSCORE;

  bnn_fc_engine #(.IL(IL), .NWORD(NWORD), .NOUT(NOUT), .RLAT(RLAT), .THRESH(THR)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iDATA(iDATA), .iWEIGHT(iWEIGHT),
    .oRADDR(oRADDR), .oWADDR(oWADDR), .oREN(oREN), .oBUSY(oBUSY), .oDONE(oDONE),
    .oDATA(oDATA), .oCLASS(oCLASS), .oSCORE(oSCORE)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [2:0] data;
    logic [1:0] cls;
    logic [5:0] score;
    int         startCycle;
  } expT;

  expT expQ[$];
  expT e;
  int checks = 0, errors = 0, cycleCnt = 0, renCount = 0;
  logic [7:0] dataMem [NWORD];
  logic [7:0] weightMem [N];
  logic [7:0] dPipe, wPipe;

  always @(posedge iCLK) cycleCnt <= cycleCnt + 1;

  // Two-cycle read latency memories
  always @(posedge iCLK) begin
    dPipe   <= dataMem[oRADDR];
    wPipe   <= weightMem[oWADDR];
    iDATA   <= dPipe;
    iWEIGHT <= wPipe;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reference: sum of matching bits per neuron, threshold, lowest-index argmax
  task automatic pushExpect();
    expT x;
    int s;
    x.data = '0;
    x.cls = '0;
    x.score = '0;
    for (int n = 0; n < NOUT; n++) begin
      s = 0;
      for (int w = 0; w < NWORD; w++) s += $countones(~(dataMem[w] ^ weightMem[n*NWORD+w]));
      x.data[n] = (s >= THR);
      if (n == 0 || s > int'(x.score)) begin
        x.score = 6'(s);
        x.cls = 2'(n);
      end
    end
    x.startCycle = cycleCnt;
    expQ.push_back(x);
  endtask

  always @(negedge iCLK) begin
    if (iRST) begin
      renCount = 0;
    end else begin
      if (oREN) begin
        checkOutput("waddr", 32'(oWADDR), 32'(renCount));
        checkOutput("raddr", 32'(oRADDR), 32'(renCount % NWORD));
        renCount++;
      end else begin
        checkOutput("idle_addr", {26'd0, oRADDR, oWADDR}, 32'd0);
      end
      if (oDONE) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done actual=1 expected=0 cycle=%0d", cycleCnt);
        end else begin
          e = expQ.pop_front();
          checkOutput("odata", 32'(oDATA), 32'(e.data));
          checkOutput("oclass", 32'(oCLASS), 32'(e.cls));
          checkOutput("oscore", 32'(oSCORE), 32'(e.score));
          checkOutput("done_latency", 32'(cycleCnt - e.startCycle), 32'(LAT));
          checkOutput("ren_cycles", 32'(renCount), 32'(N));
        end
        renCount = 0;
      end
    end
  end

  task automatic waitDone();
    int k = 0;
    while (!oDONE && k < 100) begin
      @(posedge iCLK); #1;
      k++;
    end
    if (!oDONE) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout actual=0 expected=1");
    end
  endtask

  task automatic applyStimulus();
    @(posedge iCLK); #1;
    iSTART = 1'b1;
    pushExpect();
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    waitDone();
    @(posedge iCLK); #1;
  endtask

  task automatic fillMem(input logic [7:0] d, input logic [7:0] w);
    for (int i = 0; i < NWORD; i++) dataMem[i] = d;
    for (int i = 0; i < N; i++) weightMem[i] = w;
  endtask

  task automatic randomMem();
    for (int i = 0; i < NWORD; i++) dataMem[i] = 8'($urandom);
    for (int i = 0; i < N; i++) weightMem[i] = 8'($urandom);
  endtask

  initial begin
    iRST = 1'b1;
    iSTART = 1'b0;
    fillMem(8'hFF, 8'hFF);
    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b0;
    checkOutput("rst_odata", 32'(oDATA), 32'd0);
    checkOutput("rst_oclass", 32'(oCLASS), 32'd0);
    checkOutput("rst_oscore", 32'(oSCORE), 32'd0);
    checkOutput("rst_ctrl", {29'd0, oBUSY, oDONE, oREN}, 32'd0);

    // All ones: every neuron sums to 32, tie resolves to class 0
    applyStimulus();

    // Neuron 1 sees inverted weights
    randomMem();
    for (int w = 0; w < NWORD; w++)
      for (int n = 0; n < NOUT; n++)
        weightMem[n*NWORD+w] = (n == 1) ? ~dataMem[w] : dataMem[w];
    applyStimulus();
    weightMem[2*NWORD+1] = dataMem[1] ^ 8'h01;
    applyStimulus();

    // Exactly at threshold, then one below on neuron 2
    fillMem(8'h0F, 8'hFF);
    applyStimulus();
    weightMem[2*NWORD+3] = 8'hFE;
    applyStimulus();

    // Starts during RUN and during DONE are ignored; start right after DONE runs
    randomMem();
    @(posedge iCLK); #1;
    iSTART = 1'b1;
    pushExpect();
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    repeat (4) @(posedge iCLK);
    #1 iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    waitDone();
    iSTART = 1'b1;
    randomMem();
    @(posedge iCLK); #1;
    pushExpect();
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    waitDone();
    @(posedge iCLK); #1;

    for (int r = 0; r < 4; r++) begin
      randomMem();
      applyStimulus();
    end

    // Mid-run reset clears everything and produces no completion
    fillMem(8'hFF, 8'hFF);
    applyStimulus();
    randomMem();
    @(posedge iCLK); #1;
    iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    repeat (6) @(posedge iCLK);
    #1 iRST = 1'b1;
    @(posedge iCLK); #1;
    iRST = 1'b0;
    checkOutput("midrst_odata", 32'(oDATA), 32'd0);
    checkOutput("midrst_oclass", 32'(oCLASS), 32'd0);
    checkOutput("midrst_oscore", 32'(oSCORE), 32'd0);
    checkOutput("midrst_ctrl", {29'd0, oBUSY, oDONE, oREN}, 32'd0);
    repeat (25) @(posedge iCLK);
    #1;
    applyStimulus();

    repeat (5) @(posedge iCLK);
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
